// File: rtl/audio_pkg.sv
// Shared definitions for the I2S receiver: FSM state encoding, default word width
// and FIFO depth used when AUDIO_I2S_RX_FIFO_EN is defined.
package audio_pkg;

    typedef enum logic [1:0] {
        StSync,
        StLeft,
        StRight
    } state_e;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-flop synchronizer with registered rise detect; o_q is delayed to stay aligned
// with o_rise so samples taken on a rise see the synced value at that rise.
module audio_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
        end
    end

    assign o_q    = r_prev;
    assign o_rise = r_rise;

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S stereo receiver: synced SCK/WS/SD, SYNC/LEFT/RIGHT framing FSM, MSB-aligned words.
// Define AUDIO_I2S_RX_FIFO_EN for a 4-entry output FIFO instead of a holding register.
module audio_i2s_rx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ena,
    input  logic              i_i2s_sck,
    input  logic              i_i2s_ws,
    input  logic              i_i2s_sd,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_left,
    output logic [DATA_W-1:0] o_out_right,
    output logic              o_ovf,
    input  logic              i_ovf_clr
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic              w_sck_rise, w_ws, w_sd, w_unused_ws_rise, w_unused_sd_rise;
    logic              w_rise, w_trans, w_latch_left, w_push, w_pop, w_ovf_set;
    logic [DATA_W-1:0] w_word;
    state_e            r_state, w_state_next;
    logic              r_ws_last, r_ovf;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift, r_left;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_i2s_sck), .o_q(), .o_rise(w_sck_rise)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_i2s_ws), .o_q(w_ws), .o_rise(w_unused_ws_rise)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_i2s_sd), .o_q(w_sd), .o_rise(w_unused_sd_rise)
    );

    assign w_rise  = w_sck_rise & i_ena;
    assign w_trans = w_rise & (w_ws != r_ws_last);

    // Current word including the bit arriving on this rise; bits past DATA_W are dropped.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (int'(r_cnt) == int'(DATA_W) - 1 - i) w_word[i] = w_sd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StSync;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!i_ena) begin
            w_state_next = StSync;
        end else if (w_trans) begin
            unique case (r_state)
                StSync:  if (!w_ws) w_state_next = StLeft;
                StLeft:  if (w_ws)  w_state_next = StRight;
                StRight: if (!w_ws) w_state_next = StLeft;
                default: w_state_next = StSync;
            endcase
        end
    end

    always_comb begin
        w_latch_left = w_trans && (r_state == StLeft) && w_ws;
        w_push       = w_trans && (r_state == StRight) && !w_ws;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ws_last <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_left    <= '0;
        end else if (!i_ena) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_rise) begin
            r_ws_last <= w_ws;
            if (w_trans) begin
                r_cnt   <= '0;
                r_shift <= '0;
                if (w_latch_left) r_left <= w_word;
            end else begin
                r_shift <= w_word;
                if (r_cnt < CNT_W'(DATA_W)) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef AUDIO_I2S_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_fifo_l [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr, r_rd;
    logic [PTR_W:0]    r_fcnt;
    logic              w_full, w_acc;

    assign w_full    = (r_fcnt == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = o_out_valid & i_out_ready;
    assign w_acc     = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo_l[i] <= '0;
                r_fifo_r[i] <= '0;
            end
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_acc) begin
                r_fifo_l[r_wr] <= r_left;
                r_fifo_r[r_wr] <= w_word;
                r_wr           <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_acc, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign o_out_valid = (r_fcnt != '0);
    assign o_out_left  = r_fifo_l[r_rd];
    assign o_out_right = r_fifo_r[r_rd];
`else
    logic              r_valid;
    logic [DATA_W-1:0] r_out_l, r_out_r;

    assign w_pop     = r_valid & i_out_ready;
    assign w_ovf_set = w_push & r_valid & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_out_l <= '0;
            r_out_r <= '0;
        end else if (w_push && (!r_valid || w_pop)) begin
            r_valid <= 1'b1;
            r_out_l <= r_left;
            r_out_r <= w_word;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_left  = r_out_l;
    assign o_out_right = r_out_r;
`endif

    // A new overflow wins over a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ovf <= 1'b0;
        else       r_ovf <= (r_ovf & ~i_ovf_clr) | w_ovf_set;
    end

    assign o_ovf = r_ovf;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Directed bench for audio_i2s_rx: I2S frames driven at SCK = clk/8, outputs checked
// against hand-computed words. Define AUDIO_I2S_RX_FIFO_EN to exercise the FIFO build.
module tb_audio_i2s_rx;

    logic        clk = 1'b0;
    logic        rst, ena, sck, ws, sd, out_ready, ovf_clr;
    logic        out_valid, ovf;
    logic [15:0] out_left, out_right;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    int          valid_cyc = 0;
    int          n_valid = 0;
    int          base;
    logic        prev_valid = 1'b0;
    logic [15:0] cap_l = '0;
    logic [15:0] cap_r = '0;
    logic [15:0] word;

    always #5 clk = ~clk;

    audio_i2s_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena),
        .i_i2s_sck(sck), .i_i2s_ws(ws), .i_i2s_sd(sd),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_left(out_left), .o_out_right(out_right),
        .o_ovf(ovf), .i_ovf_clr(ovf_clr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
            cap_l     <= out_left;
            cap_r     <= out_right;
        end
        prev_valid <= out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a clk edge; WS/SD change together with the SCK fall.
    task automatic send_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge clk);
        #1 sck = 1'b0;
    endtask

    // Bits hi..0 of a slot on channel w; WS flips one bit early (on the LSB).
    task automatic send_bits(input logic w, input logic [31:0] data, input int hi);
        for (int i = hi; i >= 0; i--) send_bit((i == 0) ? ~w : w, data[i]);
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_bits(1'b0, l, n - 1);
        send_bits(1'b1, r, n - 1);
    endtask

    task automatic wait_pulses(input string tag, input int target);
        for (int k = 0; k < 40 && n_valid < target; k++) @(posedge clk);
        @(negedge clk);
        check(tag, n_valid, target);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst valid", out_valid, 0);
        check("rst left", out_left, 0);
        check("rst right", out_right, 0);
        check("rst ovf", ovf, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Right slot ending in WS 1->0 brings the FSM into LEFT.
        send_bits(1'b1, 32'h0, 15);

        base = n_valid;
        frame(32'hA5C3, 32'h1234, 16);
        wait_pulses("f16 pulses", base + 1);
        check("f16 left", cap_l, 16'hA5C3);
        check("f16 right", cap_r, 16'h1234);
        check("f16 latency", valid_cyc - rise_cyc, 4);
        check("f16 ovf", ovf, 0);

        base = n_valid;
        frame(32'h7FFF0001, 32'h8000FFFF, 32);
        wait_pulses("f32 pulses", base + 1);
        check("f32 left", cap_l, 16'h7FFF);
        check("f32 right", cap_r, 16'h8000);

        base = n_valid;
        frame(32'hAB, 32'hCD, 8);
        wait_pulses("f8 pulses", base + 1);
        check("f8 left", cap_l, 16'hAB00);
        check("f8 right", cap_r, 16'hCD00);

        out_ready = 1'b0;
        base = n_valid;
        frame(32'h1, 32'h2, 16);
        wait_pulses("ovf first pulse", base + 1);
        check("ovf before full", ovf, 0);
`ifdef AUDIO_I2S_RX_FIFO_EN
        for (int k = 1; k < 5; k++) frame(2 * k + 1, 2 * k + 2, 16);
        @(negedge clk);
        check("fifo ovf", ovf, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fifo valid", out_valid, 1);
            check("fifo left", out_left, 2 * k + 1);
            check("fifo right", out_right, 2 * k + 2);
            pop_one();
        end
`else
        frame(32'h3, 32'h4, 16);
        frame(32'h5, 32'h6, 16);
        @(negedge clk);
        check("hold valid", out_valid, 1);
        check("hold left", out_left, 16'h0001);
        check("hold right", out_right, 16'h0002);
        check("hold ovf", ovf, 1);
        pop_one();
`endif
        @(negedge clk);
        check("drained valid", out_valid, 0);
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf cleared", ovf, 0);
        out_ready = 1'b1;

        // Reset in the middle of a right slot.
        base = n_valid;
        send_bits(1'b0, 32'h1111, 15);
        word = 16'h7777;
        for (int i = 15; i >= 11; i--) send_bit(1'b1, word[i]);
        pulse_rst();
        @(negedge clk);
        check("midrst valid", out_valid, 0);
        @(posedge clk);
        #1;
        send_bits(1'b1, 32'h7777, 10);
        frame(32'h2222, 32'h3333, 16);
        wait_pulses("midrst pulses", base + 1);
        check("midrst left", cap_l, 16'h2222);
        check("midrst right", cap_r, 16'h3333);

        // Stream picked up mid left slot after reset.
        pulse_rst();
        base = n_valid;
        send_bits(1'b0, 32'h0F0F, 7);
        send_bits(1'b1, 32'h5555, 15);
        frame(32'h4444, 32'h6666, 16);
        wait_pulses("midleft pulses", base + 1);
        check("midleft left", cap_l, 16'h4444);
        check("midleft right", cap_r, 16'h6666);

        // Dropping enable mid left slot discards the partial frame.
        base = n_valid;
        word = 16'h9999;
        for (int i = 15; i >= 8; i--) send_bit(1'b0, word[i]);
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1 ena = 1'b1;
        send_bits(1'b0, 32'h9999, 7);
        send_bits(1'b1, 32'h8888, 15);
        frame(32'h1357, 32'h2468, 16);
        wait_pulses("ena pulses", base + 1);
        check("ena left", cap_l, 16'h1357);
        check("ena right", cap_r, 16'h2468);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
